alu_writeback: RTL and testbench

- Writeback stage directly downstream of the 8-bit ALU.
- Consumes the ALU's result, mul_high and 4-bit status outputs, and commits them to an 8-entry x 8-bit register file and an architectural status register.
- The status register is of the form {V,S,C,Z}; its C bit is fed back to the ALU for ADDC/SUBC.
- MULTIPLY commits its 16-bit product over two cycles. COMPARE updates flags only.

---
 rtl/alu_writeback_pkg.sv | 29 ++
 rtl/alu_writeback_if.sv | 23 ++
 rtl/alu_writeback_regfile.sv | 33 +++
 rtl/alu_writeback.sv | 88 ++++++++
 tb/tb_alu_writeback.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_writeback_pkg.sv
// Shared constants for the ALU writeback stage: sizes, opcodes, flag positions, FSM states.
package alu_writeback_pkg;

  localparam int DATA_W = 8;
  localparam int NREGS  = 8;
  localparam int RIDX_W = $clog2(NREGS);

  // Opcodes follow the upstream ALU encoding; only MULTIPLY and COMPARE alter writeback behaviour.
  localparam logic [3:0] OP_ADD      = 4'b0000;
  localparam logic [3:0] OP_SUB      = 4'b0001;
  localparam logic [3:0] OP_ADDC     = 4'b0010;
  localparam logic [3:0] OP_SUBC     = 4'b0011;
  localparam logic [3:0] OP_MULTIPLY = 4'b1110;
  localparam logic [3:0] OP_COMPARE  = 4'b1111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_V = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WB_HI = 1'b1;

  // Register index of the product high byte; wraps past the top of the file.
  function automatic logic [RIDX_W-1:0] next_idx(input logic [RIDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-to-writeback result bundle with valid/ready handshake.
interface alu_writeback_if;
  import alu_writeback_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        fsl;
  logic [RIDX_W-1:0] rd;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] mul_high;
  logic [3:0]        sreg_in;

  modport master (
    output in_valid, fsl, rd, result, mul_high, sreg_in,
    input  in_ready
  );

  modport slave (
    input  in_valid, fsl, rd, result, mul_high, sreg_in,
    output in_ready
  );

endinterface

// File: rtl/alu_writeback_regfile.sv
// Register file with one synchronous write port and two combinational read ports.
module regfile_2r1w #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr_a,
  input  logic [IDX_W-1:0] raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: commits results/flags, splits MULTIPLY into low then high byte writes.
// Optional macro ALU_WB_BYPASS_EN forwards same-cycle writes to the read ports and carry_fb.
module alu_writeback
  import alu_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  alu_writeback_if.slave    bus,
  input  logic [RIDX_W-1:0] rs_a,
  input  logic [RIDX_W-1:0] rs_b,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic [3:0]        sreg,
  output logic              carry_fb
);

  logic [0:0]        state;
  logic [RIDX_W-1:0] hold_idx;
  logic [DATA_W-1:0] hold_hi;
  logic              accept;
  logic              we;
  logic [RIDX_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;

  assign bus.in_ready = (state == ST_IDLE);
  assign accept       = bus.in_valid & bus.in_ready;

  // The WB_HI high-byte write owns the single write port; inputs are ignored then.
  always_comb begin
    we    = 1'b0;
    waddr = bus.rd;
    wdata = bus.result;
    if (state == ST_WB_HI) begin
      we    = 1'b1;
      waddr = hold_idx;
      wdata = hold_hi;
    end else if (accept && (bus.fsl != OP_COMPARE)) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sreg     <= 4'b0000;
      hold_idx <= '0;
      hold_hi  <= '0;
    end else if (state == ST_WB_HI) begin
      state <= ST_IDLE;
    end else if (accept) begin
      sreg <= bus.sreg_in;
      if (bus.fsl == OP_MULTIPLY) begin
        hold_hi  <= bus.mul_high;
        hold_idx <= next_idx(bus.rd);
        state    <= ST_WB_HI;
      end
    end
  end

  regfile_2r1w #(
    .DEPTH (NREGS),
    .WIDTH (DATA_W),
    .IDX_W (RIDX_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (rs_a),
    .raddr_b (rs_b),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

`ifdef ALU_WB_BYPASS_EN
  assign rd_a     = (we && (waddr == rs_a)) ? wdata : rf_a;
  assign rd_b     = (we && (waddr == rs_b)) ? wdata : rf_b;
  assign carry_fb = accept ? bus.sreg_in[FLAG_C] : sreg[FLAG_C];
`else
  assign rd_a     = rf_a;
  assign rd_b     = rf_b;
  assign carry_fb = sreg[FLAG_C];
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed vector table, hand sequences, randomized model run.
module tb_alu_writeback;
  import alu_writeback_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [RIDX_W-1:0] rs_a;
  logic [RIDX_W-1:0] rs_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [3:0]        sreg;
  logic              carry_fb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_writeback_if wb_if ();

  alu_writeback dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (wb_if.slave),
    .rs_a     (rs_a),
    .rs_b     (rs_b),
    .rd_a     (rd_a),
    .rd_b     (rd_b),
    .sreg     (sreg),
    .carry_fb (carry_fb)
  );

  typedef struct {
    logic [3:0]        fsl;
    logic [RIDX_W-1:0] rd;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] mul_high;
    logic [3:0]        sreg_in;
    logic [RIDX_W-1:0] rs;
    logic [DATA_W-1:0] exp_data;
    logic [3:0]        exp_sreg;
    logic              exp_ready;
  } vec_t;

  vec_t vecs [6];

  // Reference model: architectural registers, flags and an outstanding high-byte write.
  logic [DATA_W-1:0] m_regs [NREGS];
  logic [3:0]        m_sreg;
  bit                m_busy;
  logic [RIDX_W-1:0] m_hidx;
  logic [DATA_W-1:0] m_hhi;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [3:0] fsl, input logic [RIDX_W-1:0] rd,
                               input logic [DATA_W-1:0] result, input logic [DATA_W-1:0] mul_high,
                               input logic [3:0] sreg_in);
    wb_if.in_valid = valid;
    wb_if.fsl      = fsl;
    wb_if.rd       = rd;
    wb_if.result   = result;
    wb_if.mul_high = mul_high;
    wb_if.sreg_in  = sreg_in;
  endtask

  task automatic modelReset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_sreg = 4'b0000;
    m_busy = 1'b0;
    m_hidx = '0;
    m_hhi  = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    applyStimulus(1'b0, OP_ADD, '0, '0, '0, 4'b0000);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    modelReset();
  endtask

  // Applies the spec rules for the bundle presented this cycle, as of the next rising edge.
  task automatic modelCommit();
    if (m_busy) begin
      m_regs[m_hidx] = m_hhi;
      m_busy = 1'b0;
    end else if (wb_if.in_valid) begin
      m_sreg = wb_if.sreg_in;
      if (wb_if.fsl != OP_COMPARE) m_regs[wb_if.rd] = wb_if.result;
      if (wb_if.fsl == OP_MULTIPLY) begin
        m_busy = 1'b1;
        m_hidx = RIDX_W'((int'(wb_if.rd) + 1) % NREGS);
        m_hhi  = wb_if.mul_high;
      end
    end
  endtask

  function automatic logic [DATA_W-1:0] expRead(input logic [RIDX_W-1:0] idx);
`ifdef ALU_WB_BYPASS_EN
    if (m_busy && m_hidx == idx) return m_hhi;
    if (!m_busy && wb_if.in_valid && wb_if.fsl != OP_COMPARE && wb_if.rd == idx) return wb_if.result;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic expCarry();
`ifdef ALU_WB_BYPASS_EN
    if (!m_busy && wb_if.in_valid) return wb_if.sreg_in[FLAG_C];
`endif
    return m_sreg[FLAG_C];
  endfunction

  initial begin
    vecs[0] = '{OP_ADD,      3'd3, 8'h5A, 8'h00, 4'b0000, 3'd3, 8'h5A, 4'b0000, 1'b1};
    vecs[1] = '{OP_ADD,      3'd2, 8'h77, 8'h00, 4'b0000, 3'd2, 8'h77, 4'b0000, 1'b1};
    vecs[2] = '{OP_COMPARE,  3'd2, 8'h01, 8'h00, 4'b0001, 3'd2, 8'h77, 4'b0001, 1'b1};
    vecs[3] = '{OP_SUB,      3'd5, 8'h33, 8'h00, 4'b0010, 3'd5, 8'h33, 4'b0010, 1'b1};
    vecs[4] = '{4'b1100,     3'd6, 8'hA5, 8'h00, 4'b1001, 3'd6, 8'hA5, 4'b1001, 1'b1};
    vecs[5] = '{OP_MULTIPLY, 3'd7, 8'h10, 8'hC3, 4'b0100, 3'd7, 8'h10, 4'b0100, 1'b0};

    rst_n = 1'b0;
    rs_a  = '0;
    rs_b  = '0;
    applyStimulus(1'b0, OP_ADD, '0, '0, '0, 4'b0000);
    #3;
    checkOutput("reset_sreg", 32'(sreg), 32'h0);
    checkOutput("reset_rd_a", 32'(rd_a), 32'h0);
    #9 rst_n = 1'b1;
    #1 checkOutput("reset_ready", 32'(wb_if.in_ready), 32'h1);

    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      applyStimulus(1'b1, vecs[v].fsl, vecs[v].rd, vecs[v].result, vecs[v].mul_high, vecs[v].sreg_in);
      rs_a = vecs[v].rs;
      @(posedge clk);
      #1 wb_if.in_valid = 1'b0;
      checkOutput($sformatf("vec%0d_data", v), 32'(rd_a), 32'(vecs[v].exp_data));
      checkOutput($sformatf("vec%0d_sreg", v), 32'(sreg), 32'(vecs[v].exp_sreg));
      checkOutput($sformatf("vec%0d_ready", v), 32'(wb_if.in_ready), 32'(vecs[v].exp_ready));
      checkOutput($sformatf("vec%0d_carry", v), 32'(carry_fb), 32'(vecs[v].exp_sreg[FLAG_C]));
    end

    // Still in WB_HI from the MULTIPLY rd=7: offered bundle must not be consumed, high byte wraps to R0.
    applyStimulus(1'b1, OP_ADD, 3'd1, 8'h55, 8'h00, 4'b1111);
    rs_a = 3'd0;
    rs_b = 3'd1;
    @(posedge clk);
    #1 wb_if.in_valid = 1'b0;
    checkOutput("mul_hi_r0", 32'(rd_a), 32'hC3);
    checkOutput("mul_hi_ready", 32'(wb_if.in_ready), 32'h1);
    checkOutput("mul_hi_sreg", 32'(sreg), 32'b0100);
    @(posedge clk);
    #1 checkOutput("wbhi_not_consumed", 32'(rd_b), 32'h00);

    // Carry feedback: committed carry is 0 here; SUB sets C.
    @(negedge clk);
    applyStimulus(1'b1, OP_SUB, 3'd5, 8'h10, 8'h00, 4'b0010);
`ifdef ALU_WB_BYPASS_EN
    #1 checkOutput("carry_sub_cycle", 32'(carry_fb), 32'h1);
`else
    #1 checkOutput("carry_sub_cycle", 32'(carry_fb), 32'h0);
`endif
    @(posedge clk);
    #1 wb_if.in_valid = 1'b0;
    checkOutput("carry_after_sub", 32'(carry_fb), 32'h1);
    applyStimulus(1'b1, OP_ADDC, 3'd6, 8'h20, 8'h00, 4'b0000);
    @(posedge clk);
    #1 wb_if.in_valid = 1'b0;
    checkOutput("addc_sreg", 32'(sreg), 32'h0);
    checkOutput("addc_carry", 32'(carry_fb), 32'h0);

    // Same-cycle read of a register being written.
    @(negedge clk);
    applyStimulus(1'b1, OP_ADD, 3'd1, 8'h9E, 8'h00, 4'b0000);
    rs_b = 3'd1;
`ifdef ALU_WB_BYPASS_EN
    #1 checkOutput("bypass_rd_b", 32'(rd_b), 32'h9E);
`else
    #1 checkOutput("bypass_rd_b", 32'(rd_b), 32'h00);
`endif
    @(posedge clk);
    #1 wb_if.in_valid = 1'b0;
    checkOutput("rd_b_after_write", 32'(rd_b), 32'h9E);

    // Reset during WB_HI aborts the high-byte write.
    @(negedge clk);
    applyStimulus(1'b1, OP_MULTIPLY, 3'd4, 8'h11, 8'hFF, 4'b1000);
    rs_a = 3'd4;
    @(posedge clk);
    #1 wb_if.in_valid = 1'b0;
    checkOutput("rst_mul_lo", 32'(rd_a), 32'h11);
    checkOutput("rst_mul_busy", 32'(wb_if.in_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_mid_sreg", 32'(sreg), 32'h0);
    for (int i = 0; i < NREGS; i++) begin
      rs_a = RIDX_W'(i);
      #1 checkOutput($sformatf("rst_mid_r%0d", i), 32'(rd_a), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput("rst_release_ready", 32'(wb_if.in_ready), 32'h1);
    rs_a = 3'd5;
    repeat (2) @(posedge clk);
    #1 checkOutput("rst_r5_not_ff", 32'(rd_a), 32'h00);

    // Randomized run against the reference model.
    doReset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      applyStimulus(($urandom % 4) != 0, 4'($urandom), RIDX_W'($urandom), DATA_W'($urandom),
                    DATA_W'($urandom), 4'($urandom));
      rs_a = RIDX_W'($urandom);
      rs_b = RIDX_W'($urandom);
      #1;
      checkOutput("rand_ready", 32'(wb_if.in_ready), 32'(!m_busy));
      checkOutput("rand_rd_a", 32'(rd_a), 32'(expRead(rs_a)));
      checkOutput("rand_rd_b", 32'(rd_b), 32'(expRead(rs_b)));
      checkOutput("rand_sreg", 32'(sreg), 32'(m_sreg));
      checkOutput("rand_carry", 32'(carry_fb), 32'(expCarry()));
      modelCommit();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
